// File: rtl/water_dispenser.sv
// water_dispenser
//   Digit-entry controller for a water dispenser. The user keys a volume in
//   millilitres one decimal digit at a time (slide switches + add button),
//   starts dispensing with ok, and clears or aborts with cancel. During
//   dispensing the registered amount counts down once every CYC cycles.
//
// Parameters
//   NS_PER_ML        dispensing time per millilitre, in ns
//   CLOCK_PERIOD_NS  clock period in ns
//
// Ports
//   clock               system clock, rising edge
//   reset               synchronous, active-high reset
//   switches[9:0]       digit selectors, lowest set index is the digit
//   button_add          active-low, append the selected digit
//   button_ok           active-low, start dispensing
//   button_cancel       active-low, clear entry / abort dispensing
//   total_amount_in_ml  entered volume (IDLE) or remaining volume (DISPENSING)
//   state_dbg           current FSM state (0 = IDLE, 1 = DISPENSING)
//
// Handshake: there is no valid/ready interface; each button press yields
// exactly one single-cycle event on the falling edge of the synchronized
// button level, acted on three clocks after the low level is first sampled.
module water_dispenser #(
  parameter int NS_PER_ML       = 1_000_000,
  parameter int CLOCK_PERIOD_NS = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  switches,
  input  logic        button_add,
  input  logic        button_ok,
  input  logic        button_cancel,
  output logic [31:0] total_amount_in_ml,
  output logic        state_dbg
);

  localparam int CYC_RAW = (NS_PER_ML + CLOCK_PERIOD_NS - 1) / CLOCK_PERIOD_NS;
  localparam int CYC     = (CYC_RAW < 1) ? 1 : CYC_RAW;
  localparam int TW      = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CYC - 1);

  typedef enum logic {
    IDLE       = 1'b0,
    DISPENSING = 1'b1
  } state_t;

  // Button vectors are ordered {cancel, ok, add}.
  logic [9:0] sw_s1, sw_s2;
  logic [2:0] btn_s1, btn_s2, btn_s3;
  logic [2:0] evt_q;

  state_t          state, state_n;
  logic [13:0]     amount, amount_n;
  logic [2:0]      count, count_n;
  logic [TW-1:0]   tick, tick_n;

  logic [3:0]      digit;
  logic            digit_valid;

  // Synchronizers preset to the idle levels so reset never creates an event.
  // The edge detector output is registered, giving the N+3 action latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 3'b111;
      btn_s2 <= 3'b111;
      btn_s3 <= 3'b111;
      evt_q  <= '0;
    end else begin
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
      btn_s1 <= {button_cancel, button_ok, button_add};
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      evt_q  <= btn_s3 & ~btn_s2;
    end
  end

  // Lowest set switch wins; scanning downward lets the lowest index land last.
  always_comb begin
    digit = '0;
    for (int i = 9; i >= 0; i--) begin
      if (sw_s2[i]) digit = 4'(i);
    end
  end

  assign digit_valid = |sw_s2;

  always_comb begin
    state_n  = state;
    amount_n = amount;
    count_n  = count;
    tick_n   = tick;
    case (state)
      IDLE: begin
        if (evt_q[2]) begin
          amount_n = '0;
          count_n  = '0;
        end else if (evt_q[1]) begin
          if (amount != '0) begin
            state_n = DISPENSING;
            tick_n  = '0;
          end
        end else if (evt_q[0] && digit_valid && (count < 3'd4)) begin
          amount_n = amount * 14'd10 + {10'd0, digit};
          count_n  = count + 3'd1;
        end
      end
      DISPENSING: begin
        if (evt_q[2]) begin
          state_n  = IDLE;
          amount_n = '0;
          count_n  = '0;
          tick_n   = '0;
        end else if (tick == TICK_LAST) begin
          tick_n   = '0;
          amount_n = amount - 14'd1;
          if (amount == 14'd1) begin
            state_n = IDLE;
            count_n = '0;
          end
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      amount <= '0;
      count  <= '0;
      tick   <= '0;
    end else begin
      state  <= state_n;
      amount <= amount_n;
      count  <= count_n;
      tick   <= tick_n;
    end
  end

  assign total_amount_in_ml = {18'd0, amount};
  assign state_dbg          = state;

endmodule

// File: tb/tb_water_dispenser.sv
module tb_water_dispenser;

  logic        clock;
  logic        reset;
  logic [9:0]  switches;
  logic        button_add;
  logic        button_ok;
  logic        button_cancel;
  logic [31:0] total_amount_in_ml;
  logic        state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [2:0] B_ADD    = 3'b001;
  localparam logic [2:0] B_OK     = 3'b010;
  localparam logic [2:0] B_CANCEL = 3'b100;

  water_dispenser #(
    .NS_PER_ML      (1),
    .CLOCK_PERIOD_NS(20)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .switches          (switches),
    .button_add        (button_add),
    .button_ok         (button_ok),
    .button_cancel     (button_cancel),
    .total_amount_in_ml(total_amount_in_ml),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic set_sw(input logic [9:0] v);
    switches = v;
    repeat (3) @(negedge clock);
  endtask

  // Pull the masked buttons low for 'hold' cycles, release, then wait 'settle'.
  task automatic press(input logic [2:0] mask, input int hold, input int settle);
    if (mask[0]) button_add    = 1'b0;
    if (mask[1]) button_ok     = 1'b0;
    if (mask[2]) button_cancel = 1'b0;
    repeat (hold) @(negedge clock);
    button_add    = 1'b1;
    button_ok     = 1'b1;
    button_cancel = 1'b1;
    repeat (settle) @(negedge clock);
  endtask

  task automatic add_digit(input int d);
    set_sw(10'(1 << d));
    press(B_ADD, 1, 4);
  endtask

  task automatic check_amt(input string name, input int exp_amt, input logic exp_st);
    tests_run++;
    if (total_amount_in_ml !== 32'(exp_amt) || state_dbg !== exp_st) begin
      tests_failed++;
      $display("FAIL %s: got amount=%0d state=%0b, want amount=%0d state=%0b",
               name, total_amount_in_ml, state_dbg, exp_amt, exp_st);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check_amt("reset_held", 0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_amt("reset_released", 0, 1'b0);
  endtask

  task automatic test_entry;
    int digs[4] = '{3, 1, 9, 0};
    int exps[4] = '{3, 31, 319, 3190};
    for (int i = 0; i < 4; i++) begin
      add_digit(digs[i]);
      check_amt($sformatf("entry_%0d", i), exps[i], 1'b0);
    end
    add_digit(6);
    check_amt("entry_full_6", 3190, 1'b0);
    add_digit(4);
    check_amt("entry_full_4", 3190, 1'b0);
    press(B_CANCEL, 1, 4);
    check_amt("entry_cancel", 0, 1'b0);
  endtask

  task automatic test_lowest_digit;
    set_sw(10'((1 << 8) | (1 << 3) | (1 << 6)));
    press(B_ADD, 1, 4);
    check_amt("lowest_3", 3, 1'b0);
    set_sw(10'((1 << 9) | (1 << 5) | (1 << 0)));
    press(B_ADD, 1, 4);
    check_amt("lowest_0", 30, 1'b0);
    set_sw(10'd0);
    press(B_ADD, 1, 4);
    check_amt("no_switch", 30, 1'b0);
    press(B_CANCEL, 1, 4);
    check_amt("lowest_cancel", 0, 1'b0);
  endtask

  task automatic test_zero_ok;
    add_digit(0);
    add_digit(0);
    press(B_OK, 1, 4);
    check_amt("zero_ok", 0, 1'b0);
    add_digit(6);
    check_amt("zero_ok_then_6", 6, 1'b0);
    press(B_CANCEL, 1, 4);
  endtask

  task automatic test_dispense_cancel;
    add_digit(6);
    add_digit(4);
    add_digit(0);
    check_amt("disp_entry", 640, 1'b0);
    press(B_OK, 4, 0);
    check_amt("disp_start", 640, 1'b1);
    @(negedge clock);
    check_amt("disp_dec1", 639, 1'b1);
    @(negedge clock);
    check_amt("disp_dec2", 638, 1'b1);
    repeat (14) @(negedge clock);
    check_amt("disp_dec16", 624, 1'b1);
    press(B_CANCEL, 1, 4);
    check_amt("disp_cancel", 0, 1'b0);
  endtask

  task automatic test_dispense_full;
    add_digit(5);
    press(B_OK, 4, 0);
    check_amt("full_start", 5, 1'b1);
    for (int v = 4; v >= 0; v--) begin
      @(negedge clock);
      check_amt($sformatf("full_%0d", v), v, (v != 0) ? 1'b1 : 1'b0);
    end
    repeat (2) @(negedge clock);
    check_amt("full_idle", 0, 1'b0);
    add_digit(7);
    check_amt("full_then_add", 7, 1'b0);
    press(B_CANCEL, 1, 4);
  endtask

  task automatic test_hold_and_priority;
    set_sw(10'(1 << 2));
    press(B_ADD, 20, 4);
    check_amt("hold_one_digit", 2, 1'b0);
    press(B_ADD | B_CANCEL, 1, 4);
    check_amt("add_cancel_prio", 0, 1'b0);
    add_digit(3);
    set_sw(10'(1 << 4));
    press(B_ADD | B_OK, 4, 0);
    check_amt("ok_add_prio", 3, 1'b1);
    repeat (6) @(negedge clock);
    check_amt("ok_add_done", 0, 1'b0);
  endtask

  task automatic test_reset_mid_dispense;
    add_digit(9);
    press(B_OK, 4, 0);
    repeat (2) @(negedge clock);
    check_amt("mid_before_reset", 7, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_amt("mid_reset", 0, 1'b0);
    add_digit(1);
    check_amt("mid_reset_count", 1, 1'b0);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset         = 1'b1;
    switches      = '0;
    button_add    = 1'b1;
    button_ok     = 1'b1;
    button_cancel = 1'b1;
    @(negedge clock);
    test_reset();
    test_entry();
    test_lowest_digit();
    test_zero_ok();
    test_dispense_cancel();
    test_dispense_full();
    test_hold_and_priority();
    test_reset_mid_dispense();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
